csr_irq_ctrl: RTL and testbench

Parametrised machine-mode CSR and interrupt controller for the RV32 core. It succeeds the single-line CSR unit with:
- NUM_IRQ synchronised interrupt sources plus MEIP, each source configurable as level or edge.
- Fixed priority, vectored or direct trap dispatch.
- MIE/MPIE stacking, and a registered redirect FSM that holds the fetch redirect against pipeline stalls.

It sits beside the execute/commit stage, drives the PC mux on trap entry and mret, and serves CSRRW/CSRRS/CSRRC reads and writes.

---
 rtl/csr_irq_pkg.sv | 42 ++++
 rtl/irq_sync_edge.sv | 42 ++++
 rtl/csr_irq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_csr_irq_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/csr_irq_pkg.sv
// Shared definitions for the machine-mode CSR and interrupt controller:
// CSR addresses, operation and state encodings, and fixed bit positions.
package csr_irq_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_TRAP = 2'b01,
    ST_RET  = 2'b10
  } state_e;

  localparam int MIE_BIT   = 3;
  localparam int MPIE_BIT  = 7;
  localparam int MEIP_BIT  = 11;
  localparam int PLAT_BASE = 16;

  // Value a CSR instruction would leave behind, given the old contents.
  function automatic logic [31:0] csr_update(csr_op_e op, logic [31:0] old_val,
                                             logic [31:0] wdata);
    case (op)
      CSR_RW:  return wdata;
      CSR_RS:  return old_val | wdata;
      CSR_RC:  return old_val & ~wdata;
      default: return old_val;
    endcase
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt input: multi-flop synchroniser, rising-edge detector and a
// sticky pending flag. Level sources pass the synchronised line straight
// through; edge sources report the sticky flag, where a new edge beats a clear.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE        = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  input  logic clr,
  output logic pending
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sticky_q;
  logic                   sync_out;
  logic                   rise;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_q;
  assign pending  = EDGE ? sticky_q : sync_out;

  // Shift the raw line through the synchroniser chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
  end

  // Remember the last synchronised level and hold edges until cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      prev_q   <= sync_out;
      sticky_q <= rise | (sticky_q & ~clr);
    end
  end

endmodule

// File: rtl/csr_irq_ctrl.sv
// Machine-mode CSR file and interrupt controller. Serves CSRRW/RS/RC, takes
// fixed-priority interrupts (MEIP first, then irq[0], irq[1], ...), stacks
// MIE/MPIE and drives a registered fetch redirect that survives stalls.
module csr_irq_ctrl
  import csr_irq_pkg::*;
#(
  parameter int                 NUM_IRQ     = 4,
  parameter logic [NUM_IRQ-1:0] IRQ_EDGE    = '0,
  parameter int                 SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        pc,
  input  logic               stall,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               illegal_csr,
  input  logic               mret,
  input  logic               meip,
  input  logic [NUM_IRQ-1:0] irq,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic               trap_taken
);

  localparam logic [31:0] MIE_MASK =
    (32'd1 << MEIP_BIT) | (32'((64'd1 << NUM_IRQ) - 64'd1) << PLAT_BASE);

  state_e             state;
  csr_op_e            op;
  logic               st_mie, st_mpie;
  logic [31:0]        mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic               meip_pend;
  logic [NUM_IRQ-1:0] irq_pend, irq_clr;
  logic [31:0]        mip_view, mstatus_view, old_val, new_val, trap_target;
  logic               csr_hit, csr_we, take, mret_ok;
  logic [4:0]         code;

  assign op           = csr_op_e'(csr_op);
  assign mstatus_view = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};

  irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE(1'b0)) u_meip (
    .clk(clk), .reset(reset), .irq_in(meip), .clr(1'b0), .pending(meip_pend)
  );

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE(IRQ_EDGE[g])) u_src (
      .clk(clk), .reset(reset), .irq_in(irq[g]), .clr(irq_clr[g]), .pending(irq_pend[g])
    );
  end

  // Assemble the pending view that mip reads and the take logic uses.
  always_comb begin
    mip_view                       = '0;
    mip_view[MEIP_BIT]             = meip_pend;
    mip_view[PLAT_BASE +: NUM_IRQ] = irq_pend;
  end

  // Decode the address into the current CSR value; unknown addresses read 0.
  always_comb begin
    csr_hit = 1'b1;
    old_val = '0;
    case (csr_addr)
      CSR_MSTATUS:  old_val = mstatus_view;
      CSR_MIE:      old_val = mie_q;
      CSR_MTVEC:    old_val = mtvec_q;
      CSR_MSCRATCH: old_val = mscratch_q;
      CSR_MEPC:     old_val = mepc_q;
      CSR_MCAUSE:   old_val = mcause_q;
      CSR_MIP:      old_val = mip_view;
      default:      csr_hit = 1'b0;
    endcase
  end

  assign csr_rdata   = old_val;
  assign illegal_csr = (op != CSR_NONE) && !csr_hit;
  assign new_val     = csr_update(op, old_val, csr_wdata);

  assign take    = (state == ST_RUN) && st_mie && |(mip_view & mie_q) && !stall && !mret;
  assign mret_ok = (state == ST_RUN) && mret && !stall;
  assign csr_we  = (state == ST_RUN) && (op != CSR_NONE) && csr_hit && !stall && !take;

  // Software clears of edge-pending bits come from a write leaving a 0 there.
  always_comb begin
    for (int i = 0; i < NUM_IRQ; i++)
      irq_clr[i] = csr_we && (csr_addr == CSR_MIP) && !new_val[PLAT_BASE+i];
  end

  // Pick the highest-priority enabled pending cause: MEIP, then lowest irq.
  always_comb begin
    code = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (irq_pend[i] && mie_q[PLAT_BASE+i]) code = 5'(PLAT_BASE + i);
    if (meip_pend && mie_q[MEIP_BIT]) code = 5'(MEIP_BIT);
  end

  assign trap_target = {mtvec_q[31:2], 2'b00} +
                       ((mtvec_q[1:0] == 2'b01) ? {25'b0, code, 2'b00} : 32'b0);

  // CSR storage: trap entry overrides software writes; mret restacks MIE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else if (take) begin
      mepc_q   <= pc & 32'hFFFF_FFFC;
      mcause_q <= {1'b1, 26'b0, code};
      st_mpie  <= st_mie;
      st_mie   <= 1'b0;
    end else begin
      if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            st_mie  <= new_val[MIE_BIT];
            st_mpie <= new_val[MPIE_BIT];
          end
          CSR_MIE:      mie_q      <= new_val & MIE_MASK;
          CSR_MTVEC:    mtvec_q    <= new_val;
          CSR_MSCRATCH: mscratch_q <= new_val;
          CSR_MEPC:     mepc_q     <= new_val & 32'hFFFF_FFFC;
          CSR_MCAUSE:   mcause_q   <= new_val;
          default:      ;
        endcase
      end
      if (mret_ok) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end
    end
  end

  // Redirect FSM: launch on trap or mret, hold the target until unstalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_RUN;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      trap_taken     <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (take) begin
            state          <= ST_TRAP;
            redirect_valid <= 1'b1;
            redirect_pc    <= trap_target;
            trap_taken     <= 1'b1;
          end else if (mret_ok) begin
            state          <= ST_RET;
            redirect_valid <= 1'b1;
            redirect_pc    <= mepc_q;
            trap_taken     <= 1'b0;
          end else begin
            redirect_valid <= 1'b0;
            trap_taken     <= 1'b0;
          end
        end
        default: begin
          trap_taken <= 1'b0;
          if (!stall) begin
            state          <= ST_RUN;
            redirect_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_irq_ctrl.sv
// Scoreboard bench for csr_irq_ctrl: directed stimulus pushes expected CSR
// reads and redirects into queues; a negedge monitor pops and compares them.
module tb_csr_irq_ctrl;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [1:0]  OP_NONE = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        ill;
  } rd_exp_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        trap;
    int          len;
  } rd_redir_t;

  logic        clk, reset, stall, mret, meip, illegal_csr;
  logic        redirect_valid, trap_taken;
  logic [31:0] pc, csr_wdata, csr_rdata, redirect_pc;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [3:0]  irq;
  logic        read_req;

  int tests_run    = 0;
  int tests_failed = 0;
  int trap_count   = 0;

  rd_exp_t   rd_q[$];
  rd_redir_t redir_q[$];

  rd_redir_t   cur_redir;
  logic        in_redir = 1'b0;
  logic        redir_stable;
  int          redir_cnt;
  logic [31:0] redir_pc0;

  csr_irq_ctrl #(.NUM_IRQ(4), .IRQ_EDGE(4'b0100), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .pc(pc), .stall(stall), .csr_op(csr_op),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .illegal_csr(illegal_csr), .mret(mret), .meip(meip), .irq(irq),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .trap_taken(trap_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [11:0] addr,
                               input logic [31:0] wdata);
    csr_op    = op;
    csr_addr  = addr;
    csr_wdata = wdata;
    tick();
    csr_op = OP_NONE;
  endtask

  task automatic readCsr(input logic [1:0] op, input logic [11:0] addr,
                         input logic [31:0] data, input logic ill, input string name);
    rd_q.push_back('{name, data, ill});
    csr_op   = op;
    csr_addr = addr;
    read_req = 1'b1;
    tick();
    read_req = 1'b0;
    csr_op   = OP_NONE;
  endtask

  task automatic pushRedir(input string name, input logic [31:0] tpc,
                           input logic trap, input int len);
    redir_q.push_back('{name, tpc, trap, len});
  endtask

  // Monitor: compare CSR reads and every redirect burst against the queues.
  always @(negedge clk) begin
    if (read_req) begin
      if (rd_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL read_underflow: got a read with no expectation queued");
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        checkOutput({e.name, "_data"}, csr_rdata, e.data);
        checkOutput({e.name, "_ill"}, {31'b0, illegal_csr}, {31'b0, e.ill});
      end
    end
    if (trap_taken) trap_count++;
    if (redirect_valid) begin
      if (!in_redir) begin
        in_redir     = 1'b1;
        redir_cnt    = 1;
        redir_pc0    = redirect_pc;
        redir_stable = 1'b1;
        if (redir_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          cur_redir = '{"unexpected", 32'h0, 1'b0, 0};
          $display("[TB] FAIL unexpected_redirect: got pc 0x%08h, expected none", redirect_pc);
        end else begin
          cur_redir = redir_q.pop_front();
          checkOutput({cur_redir.name, "_pc"}, redirect_pc, cur_redir.pc);
          checkOutput({cur_redir.name, "_trap"}, {31'b0, trap_taken}, {31'b0, cur_redir.trap});
        end
      end else begin
        redir_cnt++;
        if (redirect_pc !== redir_pc0) redir_stable = 1'b0;
        checkOutput({cur_redir.name, "_tt_single"}, {31'b0, trap_taken}, 32'h0);
      end
    end else if (in_redir) begin
      in_redir = 1'b0;
      checkOutput({cur_redir.name, "_len"}, redir_cnt, cur_redir.len);
      checkOutput({cur_redir.name, "_stable"}, {31'b0, redir_stable}, 32'h1);
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; mret = 1'b0; meip = 1'b0; irq = '0; pc = '0;
    csr_op = OP_NONE; csr_addr = '0; csr_wdata = '0; read_req = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset values, illegal address and an mret straight out of reset.
    readCsr(OP_NONE, A_MSTATUS, 32'h1800, 1'b0, "rst_mstatus");
    readCsr(OP_NONE, A_MIE, 32'h0, 1'b0, "rst_mie");
    readCsr(OP_NONE, A_MTVEC, 32'h0, 1'b0, "rst_mtvec");
    readCsr(OP_NONE, A_MSCRATCH, 32'h0, 1'b0, "rst_mscratch");
    readCsr(OP_NONE, A_MEPC, 32'h0, 1'b0, "rst_mepc");
    readCsr(OP_NONE, A_MCAUSE, 32'h0, 1'b0, "rst_mcause");
    readCsr(OP_NONE, A_MIP, 32'h0, 1'b0, "rst_mip");
    readCsr(OP_RS, 12'h7C0, 32'h0, 1'b1, "illegal_addr");
    pushRedir("rst_mret", 32'h0, 1'b0, 1);
    mret = 1'b1; tick(); mret = 1'b0; tick(); tick();
    readCsr(OP_NONE, A_MSTATUS, 32'h1880, 1'b0, "mret_mstatus");

    // Direct-mode trap from level irq[0].
    applyStimulus(OP_RW, A_MTVEC, 32'h100);
    applyStimulus(OP_RS, A_MIE, 32'h10000);
    applyStimulus(OP_RW, A_MSTATUS, 32'h8);
    pc = 32'h40;
    pushRedir("direct_trap", 32'h100, 1'b1, 1);
    irq[0] = 1'b1; repeat (6) tick(); irq[0] = 1'b0; repeat (3) tick();
    readCsr(OP_NONE, A_MEPC, 32'h40, 1'b0, "direct_mepc");
    readCsr(OP_NONE, A_MCAUSE, 32'h8000_0010, 1'b0, "direct_mcause");
    readCsr(OP_NONE, A_MSTATUS, 32'h1880, 1'b0, "direct_mstatus");
    pushRedir("direct_mret", 32'h40, 1'b0, 1);
    mret = 1'b1; tick(); mret = 1'b0; repeat (2) tick();

    // Vectored mode: MEIP beats irq[1], then irq[1] follows the mret.
    applyStimulus(OP_RW, A_MTVEC, 32'h201);
    applyStimulus(OP_RS, A_MIE, 32'h20800);
    pc = 32'h80;
    pushRedir("vec_meip", 32'h22C, 1'b1, 1);
    meip = 1'b1; irq[1] = 1'b1; repeat (4) tick(); meip = 1'b0;
    readCsr(OP_NONE, A_MCAUSE, 32'h8000_000B, 1'b0, "vec_meip_mcause");
    readCsr(OP_NONE, A_MEPC, 32'h80, 1'b0, "vec_meip_mepc");
    tick();
    pushRedir("vec_mret", 32'h80, 1'b0, 1);
    pushRedir("vec_irq1", 32'h244, 1'b1, 1);
    mret = 1'b1; tick(); mret = 1'b0; repeat (4) tick();
    irq[1] = 1'b0;
    readCsr(OP_NONE, A_MCAUSE, 32'h8000_0011, 1'b0, "vec_irq1_mcause");
    tick(); tick();

    // Edge source irq[2]: sticky, software clear, set beats clear.
    irq[2] = 1'b1; tick(); irq[2] = 1'b0; repeat (4) tick();
    readCsr(OP_NONE, A_MIP, 32'h0004_0000, 1'b0, "edge_sticky");
    applyStimulus(OP_RC, A_MIP, 32'h0004_0000);
    readCsr(OP_NONE, A_MIP, 32'h0, 1'b0, "edge_cleared");
    irq[2] = 1'b1; tick(); irq[2] = 1'b0; tick();
    applyStimulus(OP_RC, A_MIP, 32'h0004_0000);
    readCsr(OP_NONE, A_MIP, 32'h0004_0000, 1'b0, "edge_set_wins");
    applyStimulus(OP_RC, A_MIP, 32'h0004_0000);
    readCsr(OP_NONE, A_MIP, 32'h0, 1'b0, "edge_final_clear");

    // Redirect held through a 3-cycle stall; CSR write during it is dropped.
    applyStimulus(OP_RS, A_MSTATUS, 32'h8);
    pc = 32'hC0;
    pushRedir("stall_trap", 32'h240, 1'b1, 4);
    irq[0] = 1'b1; repeat (3) tick();
    stall = 1'b1;
    applyStimulus(OP_RW, A_MSCRATCH, 32'hDEAD);
    tick(); tick();
    stall = 1'b0; tick(); tick();
    irq[0] = 1'b0;
    readCsr(OP_NONE, A_MSCRATCH, 32'h0, 1'b0, "stall_mscratch");
    readCsr(OP_NONE, A_MEPC, 32'hC0, 1'b0, "stall_mepc");
    tick(); tick();

    // Asynchronous reset in the middle of a trap redirect.
    applyStimulus(OP_RS, A_MSTATUS, 32'h8);
    pc = 32'h100;
    pushRedir("reset_trap", 32'h240, 1'b1, 1);
    irq[0] = 1'b1; repeat (3) tick();
    stall = 1'b1;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("reset_async_rv", {31'b0, redirect_valid}, 32'h0);
    checkOutput("reset_async_tt", {31'b0, trap_taken}, 32'h0);
    tick();
    reset = 1'b0; stall = 1'b0; irq[0] = 1'b0;
    readCsr(OP_NONE, A_MEPC, 32'h0, 1'b0, "reset_mepc");
    readCsr(OP_NONE, A_MSTATUS, 32'h1800, 1'b0, "reset_mstatus");
    repeat (3) tick();

    checkOutput("read_queue_empty", rd_q.size(), 32'h0);
    checkOutput("redir_queue_empty", redir_q.size(), 32'h0);
    checkOutput("trap_count", trap_count, 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
